// File: rtl/wb_write_arbiter.sv
// Register-file write-port arbiter: pipeline writeback has priority, multiply/divide
// results are buffered in a small FIFO and drained into free writeback slots.
module wb_write_arbiter #(
    parameter int unsigned DEPTH        = 2,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     pipe_regwrite,
    input  logic [4:0]               pipe_rd,
    input  logic [31:0]              pipe_data,
    input  logic                     md_valid,
    input  logic [4:0]               md_rd,
    input  logic [31:0]              md_data,
    output logic                     md_ready,
    input  logic [4:0]               q_rs1,
    input  logic [4:0]               q_rs2,
    input  logic [4:0]               q_rd,
    output logic                     pend_rs1,
    output logic                     pend_rs2,
    output logic                     pend_rd,
    output logic                     stall_req,
    output logic                     rf_regwrite,
    output logic [4:0]               rf_writereg,
    output logic [31:0]              rf_writedata,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

    logic [4:0]       r_rd   [DEPTH];
    logic [31:0]      r_data [DEPTH];
    logic [DEPTH-1:0] r_vld;
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic [SW-1:0]    r_starve;
    logic             r_stall;
    logic             r_rf_we;
    logic [4:0]       r_rf_rd;
    logic [31:0]      r_rf_data;

    logic             w_slot_used;
    logic             w_ready;
    logic             w_push;
    logic             w_pop;
    logic [CW-1:0]    w_count_nxt;
    logic [SW-1:0]    w_starve_nxt;
    logic             w_rf_we_nxt;
    logic [4:0]       w_rf_rd_nxt;
    logic [31:0]      w_rf_data_nxt;
    logic             w_pend_rs1;
    logic             w_pend_rs2;
    logic             w_pend_rd;

    // Slot decision, FIFO bookkeeping and starvation tracking.
    always_comb begin
        w_slot_used   = pipe_regwrite && (pipe_rd != 5'd0);
        w_ready       = (r_count < CW'(DEPTH));
        w_push        = md_valid && w_ready && (md_rd != 5'd0);
        w_pop         = !w_slot_used && (r_count != CW'(0));
        w_count_nxt   = r_count;
        w_starve_nxt  = r_starve;
        w_rf_we_nxt   = 1'b0;
        w_rf_rd_nxt   = 5'd0;
        w_rf_data_nxt = 32'd0;

        if (w_push && !w_pop) begin
            w_count_nxt = r_count + CW'(1);
        end else if (w_pop && !w_push) begin
            w_count_nxt = r_count - CW'(1);
        end

        if ((r_count == CW'(0)) || w_pop) begin
            w_starve_nxt = SW'(0);
        end else if (r_starve < SW'(STARVE_LIMIT)) begin
            w_starve_nxt = r_starve + SW'(1);
        end

        if (w_slot_used) begin
            w_rf_we_nxt   = 1'b1;
            w_rf_rd_nxt   = pipe_rd;
            w_rf_data_nxt = pipe_data;
        end else if (w_pop) begin
            w_rf_we_nxt   = 1'b1;
            w_rf_rd_nxt   = r_rd[r_rd_ptr];
            w_rf_data_nxt = r_data[r_rd_ptr];
        end
    end

    // Hazard lookups: an entry stays pending through its pop cycle.
    always_comb begin
        w_pend_rs1 = 1'b0;
        w_pend_rs2 = 1'b0;
        w_pend_rd  = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (r_vld[AW'(i)]) begin
                if (r_rd[AW'(i)] == q_rs1) w_pend_rs1 = 1'b1;
                if (r_rd[AW'(i)] == q_rs2) w_pend_rs2 = 1'b1;
                if (r_rd[AW'(i)] == q_rd)  w_pend_rd  = 1'b1;
            end
        end
        w_pend_rs1 = w_pend_rs1 && (q_rs1 != 5'd0);
        w_pend_rs2 = w_pend_rs2 && (q_rs2 != 5'd0);
        w_pend_rd  = w_pend_rd  && (q_rd  != 5'd0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_rd[AW'(i)]   <= 5'd0;
                r_data[AW'(i)] <= 32'd0;
            end
            r_vld     <= '0;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_starve  <= '0;
            r_stall   <= 1'b0;
            r_rf_we   <= 1'b0;
            r_rf_rd   <= 5'd0;
            r_rf_data <= 32'd0;
        end else begin
            // Push and pop never target the same slot: push needs room, pop needs data.
            if (w_pop) begin
                r_vld[r_rd_ptr] <= 1'b0;
                r_rd_ptr        <= r_rd_ptr + AW'(1);
            end
            if (w_push) begin
                r_rd[r_wr_ptr]   <= md_rd;
                r_data[r_wr_ptr] <= md_data;
                r_vld[r_wr_ptr]  <= 1'b1;
                r_wr_ptr         <= r_wr_ptr + AW'(1);
            end
            r_count   <= w_count_nxt;
            r_starve  <= w_starve_nxt;
            r_stall   <= (w_starve_nxt == SW'(STARVE_LIMIT));
            r_rf_we   <= w_rf_we_nxt;
            r_rf_rd   <= w_rf_rd_nxt;
            r_rf_data <= w_rf_data_nxt;
        end
    end

    assign md_ready     = rst && w_ready;
    assign pend_rs1     = w_pend_rs1;
    assign pend_rs2     = w_pend_rs2;
    assign pend_rd      = w_pend_rd;
    assign stall_req    = r_stall;
    assign rf_regwrite  = r_rf_we;
    assign rf_writereg  = r_rf_rd;
    assign rf_writedata = r_rf_data;
    assign fifo_count   = r_count;

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Randomized and directed stimulus for wb_write_arbiter, checked against a queue-based
// reference model of the write-port arbitration rules.
module tb_wb_write_arbiter;

    localparam int unsigned DEPTH        = 2;
    localparam int unsigned STARVE_LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        pipe_regwrite = 1'b0;
    logic [4:0]  pipe_rd = 5'd0;
    logic [31:0] pipe_data = 32'd0;
    logic        md_valid = 1'b0;
    logic [4:0]  md_rd = 5'd0;
    logic [31:0] md_data = 32'd0;
    logic        md_ready;
    logic [4:0]  q_rs1 = 5'd0;
    logic [4:0]  q_rs2 = 5'd0;
    logic [4:0]  q_rd = 5'd0;
    logic        pend_rs1, pend_rs2, pend_rd, stall_req;
    logic        rf_regwrite;
    logic [4:0]  rf_writereg;
    logic [31:0] rf_writedata;
    logic [1:0]  fifo_count;

    wb_write_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk(clk), .rst(rst),
        .pipe_regwrite(pipe_regwrite), .pipe_rd(pipe_rd), .pipe_data(pipe_data),
        .md_valid(md_valid), .md_rd(md_rd), .md_data(md_data), .md_ready(md_ready),
        .q_rs1(q_rs1), .q_rs2(q_rs2), .q_rd(q_rd),
        .pend_rs1(pend_rs1), .pend_rs2(pend_rs2), .pend_rd(pend_rd),
        .stall_req(stall_req),
        .rf_regwrite(rf_regwrite), .rf_writereg(rf_writereg), .rf_writedata(rf_writedata),
        .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    // Reference model state
    ent_t        mq[$];
    logic        e_we;
    logic [4:0]  e_rd;
    logic [31:0] e_data;
    int          e_starve;
    logic        e_stall;
    logic        g_acc;

    int n_vec  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic pend_of(input logic [4:0] a);
        if (a == 5'd0) return 1'b0;
        foreach (mq[i]) if (mq[i].rd == a) return 1'b1;
        return 1'b0;
    endfunction

    task automatic mdl_reset();
        mq.delete();
        e_we = 1'b0; e_rd = 5'd0; e_data = 32'd0;
        e_starve = 0; e_stall = 1'b0; g_acc = 1'b0;
    endtask

    // Drive one cycle at the negedge, check outputs, then advance the model.
    task automatic step(input logic pw, input logic [4:0] prd, input logic [31:0] pd,
                        input logic mv, input logic [4:0] mrd, input logic [31:0] mdat,
                        input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] d);
        logic exp_ready;
        logic used;
        logic pop;
        int   size_before;
        pipe_regwrite = pw; pipe_rd = prd; pipe_data = pd;
        md_valid = mv; md_rd = mrd; md_data = mdat;
        q_rs1 = s1; q_rs2 = s2; q_rd = d;
        #1;
        exp_ready = (mq.size() < DEPTH);
        chk("md_ready",   64'(md_ready),     64'(exp_ready));
        chk("pend_rs1",   64'(pend_rs1),     64'(pend_of(s1)));
        chk("pend_rs2",   64'(pend_rs2),     64'(pend_of(s2)));
        chk("pend_rd",    64'(pend_rd),      64'(pend_of(d)));
        chk("stall_req",  64'(stall_req),    64'(e_stall));
        chk("rf_we",      64'(rf_regwrite),  64'(e_we));
        chk("rf_reg",     64'(rf_writereg),  64'(e_rd));
        chk("rf_data",    64'(rf_writedata), 64'(e_data));
        chk("fifo_count", 64'(fifo_count),   64'(mq.size()));

        size_before = mq.size();
        used = pw && (prd != 5'd0);
        pop  = !used && (size_before > 0);
        if (used) begin
            e_we = 1'b1; e_rd = prd; e_data = pd;
        end else if (pop) begin
            e_we = 1'b1; e_rd = mq[0].rd; e_data = mq[0].data;
            void'(mq.pop_front());
        end else begin
            e_we = 1'b0; e_rd = 5'd0; e_data = 32'd0;
        end
        if (size_before == 0 || pop) e_starve = 0;
        else if (e_starve < STARVE_LIMIT) e_starve++;
        e_stall = (e_starve == STARVE_LIMIT);
        g_acc = mv && exp_ready;
        if (g_acc && mrd != 5'd0) mq.push_back('{rd: mrd, data: mdat});
        @(negedge clk);
    endtask

    initial begin
        logic        h_hold;
        logic [4:0]  h_rd;
        logic [31:0] h_data;
        logic        pw, mv;
        logic [4:0]  prd, mrd;
        logic [31:0] mdat;

        mdl_reset();
        #12;
        chk("rst_rf_we",   64'(rf_regwrite),  64'd0);
        chk("rst_md_ready", 64'(md_ready),    64'd0);
        chk("rst_count",   64'(fifo_count),   64'd0);
        @(negedge clk);
        rst = 1'b1;

        // Pipe-only write
        step(1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'd0, 5'd5, 5'd0, 5'd0);
        step(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 5'd0, 5'd0, 5'd0);

        // MD result into free slots
        step(0, 5'd0, 32'd0, 1, 5'd7, 32'h12345678, 5'd7, 5'd0, 5'd0);
        step(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 5'd7, 5'd7, 5'd7);
        step(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 5'd7, 5'd0, 5'd0);
        step(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 5'd0, 5'd0, 5'd0);

        // Priority, fill, and starvation until stall_req
        step(1, 5'd1, 32'h11, 1, 5'd10, 32'hA0, 5'd10, 5'd0, 5'd0);
        step(1, 5'd2, 32'h22, 1, 5'd11, 32'hB0, 5'd10, 5'd11, 5'd0);
        for (int k = 3; k < 20 && !e_stall; k++)
            step(1, 5'(k), 32'(k), 1, 5'd12, 32'hC0, 5'd10, 5'd11, 5'd12);
        chk("stall_reached", 64'(e_stall), 64'd1);
        step(0, 5'd0, 32'd0, 1, 5'd12, 32'hC0, 5'd10, 5'd11, 5'd12);
        step(1, 5'd6, 32'h66, 1, 5'd12, 32'hC0, 5'd11, 5'd12, 5'd0);
        step(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 5'd11, 5'd12, 5'd0);
        step(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 5'd12, 5'd0, 5'd0);
        step(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 5'd0, 5'd0, 5'd0);

        // x0 handling
        step(1, 5'd3, 32'h33, 1, 5'd9, 32'h99, 5'd9, 5'd0, 5'd0);
        step(1, 5'd0, 32'hFF, 0, 5'd0, 32'd0, 5'd9, 5'd0, 5'd9);
        step(1, 5'd4, 32'h44, 1, 5'd0, 32'h55, 5'd0, 5'd0, 5'd0);
        step(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 5'd0, 5'd0, 5'd0);

        // Async reset with two entries buffered
        step(1, 5'd1, 32'h1, 1, 5'd20, 32'h200, 5'd0, 5'd0, 5'd0);
        step(1, 5'd2, 32'h2, 1, 5'd21, 32'h210, 5'd20, 5'd21, 5'd0);
        pipe_regwrite = 1'b0; md_valid = 1'b0;
        q_rs1 = 5'd20; q_rs2 = 5'd21; q_rd = 5'd20;
        @(posedge clk); #2;
        rst = 1'b0; #1;
        chk("ar_rf_we",   64'(rf_regwrite),  64'd0);
        chk("ar_rf_reg",  64'(rf_writereg),  64'd0);
        chk("ar_rf_data", 64'(rf_writedata), 64'd0);
        chk("ar_count",   64'(fifo_count),   64'd0);
        chk("ar_ready",   64'(md_ready),     64'd0);
        chk("ar_stall",   64'(stall_req),    64'd0);
        chk("ar_pend",    64'({pend_rs1, pend_rs2, pend_rd}), 64'd0);
        mdl_reset();
        @(negedge clk);
        rst = 1'b1;
        step(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 5'd20, 5'd21, 5'd0);
        step(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 5'd20, 5'd21, 5'd0);

        // Randomized traffic obeying the MD hold and stall protocols
        h_hold = 1'b0; h_rd = 5'd0; h_data = 32'd0;
        for (int n = 0; n < 1500; n++) begin
            pw  = e_stall ? 1'b0 : ($urandom_range(0, 9) < 6);
            prd = 5'($urandom_range(0, 7));
            if (h_hold) begin
                mv = 1'b1; mrd = h_rd; mdat = h_data;
            end else begin
                mv = 1'($urandom_range(0, 1)); mrd = 5'($urandom_range(0, 7)); mdat = $urandom;
            end
            step(pw, prd, $urandom, mv, mrd, mdat,
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            h_hold = mv && !g_acc;
            h_rd = mrd; h_data = mdat;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_write_arbiter.md
Name: wb_write_arbiter

Overview:
- Writer-side front end for the register-file write port; merges two producers onto the single port (regwrite/writereg/writedata):
  - the in-order pipeline writeback stage;
  - the multicycle multiply/divide unit (RV32M).
- Pipeline writes have absolute priority. MD results are buffered in a small FIFO and drained into free writeback slots.
- A starvation counter requests a pipeline bubble when the FIFO cannot drain.
- Pending-destination lookups let the issue stage stall on RAW/WAW hazards against buffered results.

Parameters:
- DEPTH, 2, MD result FIFO entries (power of 2, >=2)
- STARVE_LIMIT, 4, cycles a non-empty FIFO may go undrained before stall_req asserts

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- pipe_regwrite  in  1  writeback stage has a write this cycle
- pipe_rd  in  5  writeback destination
- pipe_data  in  32  writeback data
- md_valid  in  1  MD unit presents a result
- md_rd  in  5  MD destination
- md_data  in  32  MD result
- md_ready  out  1  arbiter accepts MD result this cycle
- q_rs1  in  5  issue-stage source 1 query
- q_rs2  in  5  issue-stage source 2 query
- q_rd  in  5  issue-stage destination query
- pend_rs1  out  1  q_rs1 matches a buffered MD entry
- pend_rs2  out  1  q_rs2 matches a buffered MD entry
- pend_rd  out  1  q_rd matches a buffered MD entry
- stall_req  out  1  request one pipeline writeback bubble
- rf_regwrite  out  1  register-file write enable
- rf_writereg  out  5  register-file write address
- rf_writedata  out  32  register-file write data
- fifo_count  out  $clog2(DEPTH)+1  current occupancy (debug/verification)

Behaviour:
- Reset (rst=0, async): FIFO empty, fifo_count=0, starve counter=0, rf_regwrite=0, rf_writereg=0, rf_writedata=0, stall_req=0, pend_*=0.
  - md_ready goes to 1 once rst deasserts.
  - A reset mid-operation discards all buffered MD results.
- Pipe slot:
  - The slot is "used" iff pipe_regwrite=1 and pipe_rd!=0.
  - pipe_regwrite with pipe_rd=0 counts as a free slot and produces no write.
- Issue decision, per cycle:
  - If the slot is used, issue the pipe write.
  - Else if the FIFO is non-empty, pop the head and issue it.
  - Else issue nothing.
- Outputs registered:
  - rf_* reflect the decision one cycle later (latency 1 for both sources).
  - rf_regwrite=0 clears rf_writereg/rf_writedata to 0.
- MD handshake:
  - md_ready = (fifo_count < DEPTH), computed from registered state. There is no pass-through and no ready-on-pop.
  - Transfer occurs on md_valid & md_ready.
  - md_rd=0 transfers are accepted and dropped, not pushed.
  - MD data never reaches rf_* in the same cycle it is accepted; minimum MD latency is 2 cycles.
- Simultaneous push and pop (not full): both occur; count unchanged; FIFO order preserved.
- Full FIFO (fifo_count=DEPTH): md_ready=0. MD must hold md_valid/md_rd/md_data stable until accepted.
- Starvation counter:
  - Increments each cycle the FIFO is non-empty and no pop occurs.
  - Clears on a pop or when the FIFO is empty.
  - Saturates at STARVE_LIMIT.
- stall_req:
  - stall_req = (counter == STARVE_LIMIT), a registered value.
  - The pipeline must present an unused slot in the cycle after it samples stall_req=1.
  - The resulting pop clears the counter, and stall_req drops on the next edge.
- Pending lookups:
  - Combinational compare of each query against the rd of every valid FIFO entry.
  - A query of 0 always returns 0.
  - Entries being popped this cycle still count as pending; the register file is written one cycle later.
  - The issue stage must stall on pend_rs1/pend_rs2 (RAW) and pend_rd (WAW). The arbiter does not reorder writes.
- FIFO pointers: width $clog2(DEPTH), wrap modulo DEPTH. Count is kept separately to distinguish full from empty.

Test Plan:
- Pipe-only: pipe_regwrite=1, pipe_rd=5, pipe_data=0xDEADBEEF with md_valid=0 -> next cycle rf_regwrite=1, rf_writereg=5, rf_writedata=0xDEADBEEF; fifo_count stays 0.
- MD into free slot: md_valid=1, md_rd=7, md_data=0x12345678, pipe_regwrite=0 -> accepted (md_ready=1); fifo_count=1 next cycle; pend_rs1=1 for q_rs1=7; rf_* shows rd=7, data=0x12345678 two cycles after accept; fifo_count returns to 0.
- Priority and fill: pipe writes rd=1..6 on consecutive cycles while MD presents rd=10 then rd=11 -> both accepted, fifo_count=2, md_ready=0; a third MD result rd=12 is held off; rf_* carries only pipe writes.
- Starvation: keep the pipe slot used with FIFO non-empty -> stall_req=1 after STARVE_LIMIT=4 undrained cycles; the bench then drives pipe_regwrite=0 -> rd=10 is written, the counter clears, stall_req=0 on the following edge.
- x0 handling: pipe_rd=0 with pipe_regwrite=1 and FIFO holding rd=9 -> rd=9 drains in that slot. An MD result with md_rd=0 is accepted with fifo_count unchanged and no rf write.
- Async reset mid-flight: drop rst to 0 with 2 entries buffered, between clock edges -> all outputs 0 immediately; after release, fifo_count=0, md_ready=1, and no stale write appears.
